// File: rtl/gray_counter_pkg.sv
// gray_counter_pkg: end-of-range behaviour encodings shared by the counter blocks
package gray_counter_pkg;
  localparam bit WRAP = 1'b1;
  localparam bit SAT  = 1'b0;
endpackage

// File: rtl/gray_counter_gray2bin.sv
// gray2bin_n: combinational Gray-to-binary decoder, b[i] is the XOR of g[W-1:i]
module gray2bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b[i] = ^g[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down counter presenting binary and Gray forms with load and wrap/saturate
module gray_counter
  import gray_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int INIT      = 0,
  parameter bit WRAP_MODE = WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);
  localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
  logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d, load_bin, step_bin;
  logic             tc_q, tc_d, term;
  gray2bin_n #(.WIDTH(WIDTH)) u_dec (.g(load_gray), .b(load_bin));
  always_comb begin
    term     = up_dn ? (bin_q == '1) : (bin_q == '0);
    step_bin = (term && WRAP_MODE == SAT) ? bin_q : (up_dn ? bin_q + 1'b1 : bin_q - 1'b1);
    bin_d    = reset ? INIT_B : load ? load_bin : en ? step_bin : bin_q;
    // Derived from bin_d so both registers always agree; on load this equals load_gray.
    gray_d   = bin_d ^ (bin_d >> 1);
    tc_d     = !reset && !load && en && term;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q  <= INIT_B;
      gray_q <= INIT_B ^ (INIT_B >> 1);
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end
  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = tc_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed scoreboard bench over three counter configurations
module tb_gray_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] en, ld, rs;
  logic       up_dn;
  logic [7:0] lg;
  logic [3:0] b0, g0, b1, g1;
  logic [7:0] b2, g2;
  logic       t0, t1, t2;
  gray_counter #(.WIDTH(4), .INIT(0), .WRAP_MODE(1'b1)) d0 (
    .clk(clk), .reset(rs[0]), .en(en[0]), .up_dn(up_dn), .load(ld[0]),
    .load_gray(lg[3:0]), .bin(b0), .gray(g0), .tc(t0));
  gray_counter #(.WIDTH(4), .INIT(5), .WRAP_MODE(1'b0)) d1 (
    .clk(clk), .reset(rs[1]), .en(en[1]), .up_dn(up_dn), .load(ld[1]),
    .load_gray(lg[3:0]), .bin(b1), .gray(g1), .tc(t1));
  gray_counter #(.WIDTH(8), .INIT(0), .WRAP_MODE(1'b0)) d2 (
    .clk(clk), .reset(rs[2]), .en(en[2]), .up_dn(up_dn), .load(ld[2]),
    .load_gray(lg), .bin(b2), .gray(g2), .tc(t2));
  typedef struct {
    int         id;
    logic [7:0] bin;
    logic       tc;
    string      name;
  } exp_t;
  exp_t q[$];
  exp_t x;
  int total = 0;
  int bad = 0;
  logic [7:0] ab, ag;
  logic       at;
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask
  task automatic step(input int id, input bit e, input bit u, input bit l,
                      input logic [7:0] g, input bit r, input logic [7:0] eb,
                      input bit et, input string nm);
    @(negedge clk);
    en = '0; ld = '0; rs = '0;
    en[id] = e; ld[id] = l; rs[id] = r;
    up_dn = u; lg = g;
    q.push_back('{id, eb, et, nm});
  endtask
  // Monitor: each scoreboard entry is due one edge after it was issued.
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      ab = (x.id == 0) ? {4'h0, b0} : (x.id == 1) ? {4'h0, b1} : b2;
      ag = (x.id == 0) ? {4'h0, g0} : (x.id == 1) ? {4'h0, g1} : g2;
      at = (x.id == 0) ? t0 : (x.id == 1) ? t1 : t2;
      check({x.name, "_bin"}, ab, x.bin);
      check({x.name, "_gray"}, ag, x.bin ^ (x.bin >> 1));
      check({x.name, "_tc"}, {7'h0, at}, {7'h0, x.tc});
    end
  end
  initial begin
    en = '0; ld = '0; rs = 3'b111; up_dn = 1'b1; lg = '0;
    @(negedge clk);
    step(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0, "rst0");
    step(1, 1'b1, 1'b1, 1'b1, 8'h0f, 1'b1, 8'd5, 1'b0, "rst1");
    step(2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0, "rst2");
    for (int i = 1; i <= 16; i++)
      step(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'(i % 16), i == 16, "up4");
    step(0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd15, 1'b1, "dn_wrap");
    step(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, "up_wrap");
    step(0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, "hold");
    step(0, 1'b0, 1'b1, 1'b1, 8'h0d, 1'b0, 8'd9, 1'b0, "load");
    step(0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 8'd2, 1'b0, "load_en");
    step(0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd3, 1'b0, "after_load");
    step(1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'd0, 1'b0, "sat_ld0");
    step(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, "sat_dn");
    step(1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, "sat_dn2");
    step(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0, "sat_up");
    step(1, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 8'd15, 1'b0, "sat_ld15");
    step(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd15, 1'b1, "sat_top");
    step(1, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 8'd7, 1'b0, "ld7");
    step(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'd5, 1'b0, "rst_mid");
    step(1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd6, 1'b0, "resume");
    for (int i = 1; i <= 255; i++)
      step(2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'(i), 1'b0, "up8");
    step(2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd255, 1'b1, "sat8");
    step(2, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd255, 1'b1, "sat8b");
    step(2, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 8'd255, 1'b0, "ld8_top");
    step(2, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd255, 1'b0, "hold8");
    step(2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'd254, 1'b0, "dn8");
    @(negedge clk);
    en = '0; ld = '0; rs = '0;
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
